// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, FSM states and the round-robin pick used by the writeback arbiter.
package regfile_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 4;
   localparam int MAX_REQ    = 8;

   typedef enum logic {CLEAR, RUN} state_t;

   // One-hot grant of the first valid index after 'last', wrapping modulo n.
   function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid, input int n, input int last);
      logic [MAX_REQ-1:0] g;
      int idx;
      g = '0;
      for (int k = 1; k <= MAX_REQ; k++) begin
         idx = (last + k) % n;
         if (k <= n && g == '0 && valid[idx[2:0]]) g[idx[2:0]] = 1'b1;
      end
      return g;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_grant.sv
// rr_grant: combinational round-robin picker over NUM_REQ requesters.
module rr_grant
   import regfile_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic [IDX_W-1:0]   last_i,
   output logic [NUM_REQ-1:0] grant_o
);

   logic [MAX_REQ-1:0] valid_ext;
   logic [MAX_REQ-1:0] grant_ext;

   always_comb begin
      valid_ext = '0;
      valid_ext[NUM_REQ-1:0] = valid_i;
   end

   assign grant_ext = rr_pick(valid_ext, NUM_REQ, int'(last_i));

   always_comb begin
      grant_o = '0;
      for (int i = 0; i < MAX_REQ; i++) if (i < NUM_REQ) grant_o[i] = grant_ext[i];
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: clears the register file after reset, then round-robin shares its write port.
// Optional macro WB_BYPASS_EN adds read ports that forward the write currently in the output stage.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ADDR_W  = DEF_ADDR_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      hold,
   output logic                      init_done,
   output logic                      rf_write,
   output logic [ADDR_W-1:0]         rf_addr,
   output logic [DATA_W-1:0]         rf_data
`ifdef WB_BYPASS_EN
   ,
   input  logic [ADDR_W-1:0]         rd_addr_a,
   input  logic [ADDR_W-1:0]         rd_addr_b,
   input  logic [DATA_W-1:0]         rf_rdata_a,
   input  logic [DATA_W-1:0]         rf_rdata_b,
   output logic [DATA_W-1:0]         fwd_data_a,
   output logic [DATA_W-1:0]         fwd_data_b
`endif
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
   logic [IDX_W-1:0]    rr_last_q, rr_last_d;
   logic                rf_write_q, rf_write_d;
   logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
   logic [DATA_W-1:0]   rf_data_q, rf_data_d;
   logic [NUM_REQ-1:0]  grant;

   rr_grant #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
      .valid_i (req_valid),
      .last_i  (rr_last_q),
      .grant_o (grant)
   );

   always_comb begin
      state_d    = state_q;
      clr_cnt_d  = clr_cnt_q;
      rr_last_d  = rr_last_q;
      rf_write_d = 1'b0;
      rf_addr_d  = rf_addr_q;
      rf_data_d  = rf_data_q;
      req_ready  = (state_q == RUN && !hold) ? grant : '0;
      if (state_q == CLEAR) begin
         rf_write_d = 1'b1;
         rf_addr_d  = clr_cnt_q;
         rf_data_d  = '0;
         clr_cnt_d  = clr_cnt_q + 1'b1;
         state_d    = (&clr_cnt_q) ? RUN : CLEAR;
      end
      // At most one ready bit is set, so this loop acts as a one-hot mux.
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_ready[i]) begin
            rr_last_d  = IDX_W'(i);
            rf_write_d = 1'b1;
            rf_addr_d  = req_addr[i*ADDR_W +: ADDR_W];
            rf_data_d  = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= CLEAR;
         clr_cnt_q  <= '0;
         rr_last_q  <= IDX_W'(NUM_REQ - 1);
         rf_write_q <= 1'b0;
         rf_addr_q  <= '0;
         rf_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         rr_last_q  <= rr_last_d;
         rf_write_q <= rf_write_d;
         rf_addr_q  <= rf_addr_d;
         rf_data_q  <= rf_data_d;
      end
   end

   assign init_done = (state_q == RUN);
   assign rf_write  = rf_write_q;
   assign rf_addr   = rf_addr_q;
   assign rf_data   = rf_data_q;

`ifdef WB_BYPASS_EN
   assign fwd_data_a = (rf_write_q && rf_addr_q == rd_addr_a) ? rf_data_q : rf_rdata_a;
   assign fwd_data_b = (rf_write_q && rf_addr_q == rd_addr_b) ? rf_data_q : rf_rdata_b;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: randomized and directed writeback traffic checked against a queue-based reference model.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  req_valid;
   logic [11:0] req_addr;
   logic [47:0] req_data;
   logic [2:0]  req_ready;
   logic        hold;
   logic        init_done;
   logic        rf_write;
   logic [3:0]  rf_addr;
   logic [15:0] rf_data;
`ifdef WB_BYPASS_EN
   logic [3:0]  rd_addr_a, rd_addr_b;
   logic [15:0] rf_rdata_a, rf_rdata_b, fwd_data_a, fwd_data_b;
`endif

   int total = 0;
   int bad = 0;
   int k = -1;
   int rr_m = 2;
   logic [2:0]  acc_n = 3'b000;
   logic [19:0] pend [3][$];
   logic [19:0] expq [$];
   logic [15:0] rf_m [16];
   logic [15:0] regs [16];

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.NUM_REQ(3), .DATA_W(16), .ADDR_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .hold       (hold),
      .init_done  (init_done),
      .rf_write   (rf_write),
      .rf_addr    (rf_addr),
      .rf_data    (rf_data)
`ifdef WB_BYPASS_EN
      ,
      .rd_addr_a  (rd_addr_a),
      .rd_addr_b  (rd_addr_b),
      .rf_rdata_a (rf_rdata_a),
      .rf_rdata_b (rf_rdata_b),
      .fwd_data_a (fwd_data_a),
      .fwd_data_b (fwd_data_b)
`endif
   );

   // The bench plays the register file behind the write port.
   always @(posedge clk) if (rf_write) regs[rf_addr] <= rf_data;
`ifdef WB_BYPASS_EN
   assign rf_rdata_a = regs[rd_addr_a];
   assign rf_rdata_b = regs[rd_addr_b];
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] model_grant(input logic [2:0] v, input int last);
      for (int s = 1; s <= 3; s++) if (v[(last + s) % 3]) return 3'b001 << ((last + s) % 3);
      return 3'b000;
   endfunction

   // Monitor: k counts posedges since the last reset edge; sweep writes occupy k=1..16.
   always @(negedge clk) begin
      logic        w;
      logic [3:0]  wa;
      logic [15:0] wd;
      logic [19:0] e;
      logic [2:0]  g;
      acc_n = 3'b000;
      if (k >= 0) begin
         w = 1'b0;
         wa = 4'd0;
         wd = 16'd0;
         if (k == 0) begin
            chk("rst_write", {31'd0, rf_write}, 32'd0);
            chk("rst_addr", {28'd0, rf_addr}, 32'd0);
            chk("rst_data", {16'd0, rf_data}, 32'd0);
         end else if (k <= 16) begin
            w = 1'b1;
            wa = 4'(k - 1);
         end else if (expq.size() > 0) begin
            e = expq.pop_front();
            w = 1'b1;
            wa = e[19:16];
            wd = e[15:0];
         end
         if (k > 0) begin
            chk("wr_en", {31'd0, rf_write}, {31'd0, w});
            if (w) begin
               chk("wr_addr", {28'd0, rf_addr}, {28'd0, wa});
               chk("wr_data", {16'd0, rf_data}, {16'd0, wd});
            end
         end
         chk("init_done", {31'd0, init_done}, {31'd0, k >= 16});
`ifdef WB_BYPASS_EN
         chk("fwd_a", {16'd0, fwd_data_a}, {16'd0, (w && wa == rd_addr_a) ? wd : rf_m[rd_addr_a]});
         chk("fwd_b", {16'd0, fwd_data_b}, {16'd0, (w && wa == rd_addr_b) ? wd : rf_m[rd_addr_b]});
`endif
         if (w) rf_m[wa] = wd;
         g = (k >= 16 && !hold) ? model_grant(req_valid, rr_m) : 3'b000;
         chk("grant", {29'd0, req_ready}, {29'd0, g});
         acc_n = g;
         for (int i = 0; i < 3; i++) begin
            if (g[i]) begin
               expq.push_back({req_addr[i*4 +: 4], req_data[i*16 +: 16]});
               rr_m = i;
            end
         end
      end
      if (reset) begin
         k = 0;
         expq.delete();
         rr_m = 2;
      end else if (k >= 0) begin
         k++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) if (acc_n[i] && pend[i].size() > 0) void'(pend[i].pop_front());
      for (int i = 0; i < 3; i++) begin
         req_valid[i] = pend[i].size() > 0;
         if (pend[i].size() > 0) begin
            req_addr[i*4 +: 4]   = pend[i][0][19:16];
            req_data[i*16 +: 16] = pend[i][0][15:0];
         end
      end
`ifdef WB_BYPASS_EN
      rd_addr_a = 4'($urandom_range(0, 15));
      rd_addr_b = 4'($urandom_range(0, 15));
`endif
   endtask

   task automatic drain();
      int left;
      hold = 1'b0;
      for (int c = 0; c < 300; c++) begin
         left = pend[0].size() + pend[1].size() + pend[2].size();
         if (left == 0) break;
         step();
      end
      left = pend[0].size() + pend[1].size() + pend[2].size();
      chk("drain_timeout", left, 0);
      repeat (3) step();
   endtask

   initial begin
      logic [15:0] r5_exp;
      reset = 1'b1;
      hold = 1'b0;
      req_valid = 3'b000;
      req_addr = '0;
      req_data = '0;
`ifdef WB_BYPASS_EN
      rd_addr_a = 4'd0;
      rd_addr_b = 4'd0;
`endif
      for (int a = 0; a < 16; a++) rf_m[a] = 16'd0;
      repeat (3) step();
      reset = 1'b0;
      repeat (20) step();
      pend[0].push_back({4'd3, 16'hBEEF});
      drain();
      for (int n = 0; n < 6; n++)
         for (int i = 0; i < 3; i++) pend[i].push_back({4'(n + 4*i), 16'(16'h1000*(i+1) + n)});
      drain();
      r5_exp = (rr_m == 1) ? 16'hAAAA : 16'hBBBB;
      pend[1].push_back({4'd5, 16'hAAAA});
      pend[2].push_back({4'd5, 16'hBBBB});
      drain();
      chk("r5_last_grant", {16'd0, regs[5]}, {16'd0, r5_exp});
      hold = 1'b1;
      pend[0].push_back({4'd0, 16'h0A0A});
      repeat (5) step();
      drain();
      chk("r0_after_hold", {16'd0, regs[0]}, 32'h0000_0A0A);
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 3; i++)
            if ($urandom_range(0, 2) == 0 && pend[i].size() < 4)
               pend[i].push_back({4'($urandom_range(0, 15)), 16'($urandom)});
         hold = ($urandom_range(0, 7) == 0);
         reset = (c == 200);
         step();
      end
      reset = 1'b0;
      drain();
      repeat (20) step();
      for (int a = 0; a < 16; a++) chk("regfile_final", {16'd0, regs[a]}, {16'd0, rf_m[a]});
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
